// File: rtl/timeout_retry_ctrl.sv
// timeout_retry_ctrl: issues a request to a slave, waits for ack and retries
// after a watchdog timeout with a fixed idle backoff. Reports done or error.
// The optional status outputs retry_cnt and timeout_total exist only when the
// macro TIMEOUT_RETRY_STATUS_EN is defined.
module timeout_retry_ctrl #(
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        ack,
    input  logic        thresh,
    output logic        ctr_clr,
    output logic        req,
    output logic        busy,
    output logic        done,
    output logic        error
`ifdef TIMEOUT_RETRY_STATUS_EN
    ,
    output logic [3:0]  retry_cnt,
    output logic [15:0] timeout_total
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_BACKOFF = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    localparam logic [3:0]  MAX_R   = 4'(MAX_RETRY);
    localparam logic [15:0] BO_LAST = 16'(BACKOFF - 1);

    logic [2:0]  state, state_nxt;
    logic [3:0]  retry_q;
    logic [15:0] bo_cnt;

    // Next-state decode; abort overrides every other transition outside IDLE.
    always_comb begin
        state_nxt = state;
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) state_nxt = S_REQ;
                S_REQ:     state_nxt = S_WAIT;
                S_WAIT: begin
                    if (ack)
                        state_nxt = S_DONE;
                    else if (thresh)
                        state_nxt = (retry_q == MAX_R) ? S_ERR : S_BACKOFF;
                end
                S_BACKOFF: if (bo_cnt == BO_LAST) state_nxt = S_REQ;
                S_DONE:    state_nxt = S_IDLE;
                S_ERR:     state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Retry count: cleared in IDLE, bumped on each timeout that leads to a backoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retry_q <= '0;
        else if (state == S_IDLE)
            retry_q <= '0;
        else if (state == S_WAIT && state_nxt == S_BACKOFF)
            retry_q <= retry_q + 4'd1;
    end

    // Backoff counter: sits at zero outside BACKOFF so it starts from 0 on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bo_cnt <= '0;
        else if (state != S_BACKOFF)
            bo_cnt <= '0;
        else
            bo_cnt <= bo_cnt + 16'd1;
    end

`ifdef TIMEOUT_RETRY_STATUS_EN
    // Saturating tally of every watchdog timeout seen while waiting for ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout_total <= '0;
        else if (state == S_WAIT && thresh && timeout_total != 16'hFFFF)
            timeout_total <= timeout_total + 16'd1;
    end

    assign retry_cnt = retry_q;
`endif

    // Outputs decode the registered state only; the watchdog runs only in WAIT.
    assign req     = (state == S_REQ);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign error   = (state == S_ERR);
    assign ctr_clr = (state != S_WAIT);

endmodule

// File: tb/tb_timeout_retry_ctrl.sv
// Bench for timeout_retry_ctrl: table of per-cycle vectors with expected
// outputs fed through a scoreboard queue, plus hand sequences for retry,
// exhaustion and mid-transaction reset.
module tb_timeout_retry_ctrl;

    localparam int MR = 2;
    localparam int BO = 16;

    logic clk = 1'b0;
    logic rst, start, abort, ack, thresh;
    logic ctr_clr, req, busy, done, error;
`ifdef TIMEOUT_RETRY_STATUS_EN
    logic [3:0]  retry_cnt;
    logic [15:0] timeout_total;
`endif

    timeout_retry_ctrl #(.MAX_RETRY(MR), .BACKOFF(BO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ack(ack),
        .thresh(thresh), .ctr_clr(ctr_clr), .req(req), .busy(busy),
        .done(done), .error(error)
`ifdef TIMEOUT_RETRY_STATUS_EN
        , .retry_cnt(retry_cnt), .timeout_total(timeout_total)
`endif
    );

    always #5 clk = ~clk;

    // Output vector order: {req, busy, done, error, ctr_clr}
    localparam logic [4:0] IDL = 5'b00001;
    localparam logic [4:0] RQ  = 5'b11001;
    localparam logic [4:0] WT  = 5'b01000;
    localparam logic [4:0] DN  = 5'b01101;
    localparam logic [4:0] BK  = 5'b01001;
    localparam logic [4:0] ER  = 5'b01011;

    typedef struct {
        logic [3:0] in;   // {start, abort, ack, thresh}
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [4:0] outs();
        return {req, busy, done, error, ctr_clr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, let the rising edge pass.
    task automatic cyc(input logic [3:0] in);
        @(negedge clk);
        {start, abort, ack, thresh} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] in, input logic [4:0] exp, input string name);
        vec_t v;
        v.in = in; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    int n, reqs, dones, errs;
    logic [4:0] e;
`ifdef TIMEOUT_RETRY_STATUS_EN
    logic [15:0] tt0;
`endif

    initial begin
        // clean success: ack five cycles after start
        add(4'b1000, RQ,  "ok_req");
        add(4'b0000, WT,  "ok_w1");
        add(4'b0000, WT,  "ok_w2");
        add(4'b0000, WT,  "ok_w3");
        add(4'b0000, WT,  "ok_w4");
        add(4'b0010, DN,  "ok_done");
        add(4'b0000, IDL, "ok_idle");
        // ack and thresh together: ack wins
        add(4'b1000, RQ,  "at_req");
        add(4'b0000, WT,  "at_wait");
        add(4'b0011, DN,  "at_done");
        add(4'b0000, IDL, "at_idle");
        // abort coincident with ack
        add(4'b1000, RQ,  "aa_req");
        add(4'b0000, WT,  "aa_wait");
        add(4'b0110, IDL, "aa_abort");
        add(4'b0000, IDL, "aa_quiet");
        // start ignored while busy
        add(4'b1000, RQ,  "sb_req");
        add(4'b1000, WT,  "sb_req_start");
        add(4'b1000, WT,  "sb_wait_start");
        add(4'b0100, IDL, "sb_abort");
        // abort in REQ, abort/ack/thresh in IDLE ignored
        add(4'b1000, RQ,  "ar_req");
        add(4'b0100, IDL, "ar_abort");
        add(4'b0100, IDL, "idle_abort");
        add(4'b0011, IDL, "idle_ackthr");
        // ack/thresh ignored in REQ
        add(4'b1001, RQ,  "rq_req");
        add(4'b0011, WT,  "rq_ignore");
        add(4'b0100, IDL, "rq_abort");
        // abort in BACKOFF, start ignored in BACKOFF
        add(4'b1000, RQ,  "ab_req");
        add(4'b0000, WT,  "ab_wait");
        add(4'b0001, BK,  "ab_bk");
        add(4'b1000, BK,  "ab_bk_start");
        add(4'b0100, IDL, "ab_abort");
        add(4'b0000, IDL, "ab_idle");

        {start, abort, ack, thresh} = 4'b0000;
        rst = 1'b1;
        #1;
        chk("reset_outs", 32'(outs()), 32'(IDL));
`ifdef TIMEOUT_RETRY_STATUS_EN
        chk("reset_retry", 32'(retry_cnt), 0);
        chk("reset_total", 32'(timeout_total), 0);
`endif
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        cyc(4'b0000);
        chk("idle_after_reset", 32'(outs()), 32'(IDL));

        // table: push expectation as each vector is driven, pop after the edge
        foreach (tbl[i]) begin
            @(negedge clk);
            {start, abort, ack, thresh} = tbl[i].in;
            exp_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk(tbl[i].name, 32'(outs()), 32'(e));
        end

        // single retry: one timeout, BO backoff cycles, second request, ack
        cyc(4'b1000);
        cyc(4'b0000);
        cyc(4'b0001);
        n = 0;
        for (int k = 0; k < 200 && busy && !req; k++) begin
            if (ctr_clr && !done && !error) n++;
            cyc(4'b0000);
        end
        chk("retry_backoff_cycles", n, BO);
        chk("retry_second_req", 32'(req), 1);
        cyc(4'b0000);
        chk("retry_wait_clr", 32'(outs()), 32'(WT));
        cyc(4'b0010);
        chk("retry_done", 32'(outs()), 32'(DN));
`ifdef TIMEOUT_RETRY_STATUS_EN
        chk("retry_cnt_done", 32'(retry_cnt), 1);
`endif
        cyc(4'b0000);
        chk("retry_idle", 32'(outs()), 32'(IDL));
`ifdef TIMEOUT_RETRY_STATUS_EN
        chk("retry_cnt_idle", 32'(retry_cnt), 0);
        tt0 = timeout_total;
`endif

        // exhaustion: thresh held high, expect MR+1 requests then one error
        cyc(4'b1001);
        reqs = 32'(req); dones = 0; errs = 0;
        for (int k = 0; k < 500 && busy; k++) begin
            cyc(4'b0001);
            reqs  += 32'(req);
            dones += 32'(done);
            errs  += 32'(error);
            if (error) begin
                e = outs();
                chk("exh_err_outs", 32'(e), 32'(ER));
            end
        end
        chk("exh_reqs", reqs, MR + 1);
        chk("exh_errs", errs, 1);
        chk("exh_dones", dones, 0);
        chk("exh_idle", 32'(busy), 0);
`ifdef TIMEOUT_RETRY_STATUS_EN
        chk("exh_total", 32'(timeout_total - tt0), MR + 1);
`endif
        cyc(4'b0000);

        // reset in WAIT: outputs fall back immediately, no restart without start
        cyc(4'b1000);
        cyc(4'b0000);
        chk("rw_wait", 32'(outs()), 32'(WT));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_async_outs", 32'(outs()), 32'(IDL));
`ifdef TIMEOUT_RETRY_STATUS_EN
        chk("rw_total", 32'(timeout_total), 0);
        chk("rw_retry", 32'(retry_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        cyc(4'b0010);
        cyc(4'b0000);
        chk("rw_stays_idle", 32'(outs()), 32'(IDL));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timeout_retry_ctrl.md
TIMEOUT_RETRY_CTRL -- requirements
Module: timeout_retry_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3: number of re-requests issued after timeouts before error (range 0..15).
REQ-002 SHALL have parameter BACKOFF, default 16: idle cycles between a timeout and the next request (range 1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse requesting a transaction; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancels any transaction in progress.
REQ-007 SHALL have port ack  input  1  slave ready/acknowledge.
REQ-008 SHALL have port thresh  input  1  timeout flag from the downstream-ready watchdog counter.
REQ-009 SHALL have port ctr_clr  output  1  clear to the watchdog counter's ready input; high holds the counter at zero.
REQ-010 SHALL have port req  output  1  one-cycle request pulse to the slave.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on success.
REQ-013 SHALL have port error  output  1  one-cycle pulse when retries are exhausted.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT, BACKOFF, DONE, ERR with registered state.
REQ-015 SHALL, in IDLE: ctr_clr=1, retry count cleared; start=1 -> REQ next cycle; otherwise remain.
REQ-016 SHALL, in REQ: req=1, ctr_clr=1 for exactly one cycle, then -> WAIT.
REQ-017 SHALL, in WAIT: ctr_clr=0; ack=1 -> DONE; else thresh=1 -> ERR if retry count == MAX_RETRY, otherwise increment retry count and -> BACKOFF; else remain.
REQ-018 SHALL give ack priority over thresh when both are high in the same WAIT cycle.
REQ-019 SHALL, in BACKOFF: ctr_clr=1, 16-bit backoff counter loads 0 on entry, increments each cycle, and -> REQ in the cycle it reaches BACKOFF-1 (exactly BACKOFF cycles in state).
REQ-020 SHALL, in DONE: done=1 for one cycle, then -> IDLE; in ERR: error=1 for one cycle, then -> IDLE.
REQ-021 SHALL ignore start in all states except IDLE; ack and thresh are ignored outside WAIT.
REQ-022 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle with no done/error pulse; abort has priority over ack, thresh and all other transitions.
REQ-023 SHALL drive req, done, error, ctr_clr, busy as decodes of the registered state (no combinational path from inputs to outputs).
REQ-024 SHALL with MAX_RETRY=0 go WAIT -> ERR on first timeout; total requests issued per transaction = MAX_RETRY+1.
REQ-025 SHALL size retry count at 4 bits; it never exceeds MAX_RETRY.

Reset
REQ-026 SHALL on rst=1, asynchronously: state=IDLE, retry count=0, backoff counter=0; hence ctr_clr=1, req=0, busy=0, done=0, error=0.
REQ-027 SHALL on rst asserted mid-transaction drop req/busy immediately with no done/error pulse; operation restarts only on a new start after rst falls.

Configuration
REQ-028 SHALL, when macro TIMEOUT_RETRY_STATUS_EN is defined, add output retry_cnt (4 bits, current retry count, reset 0, held at final value in DONE/ERR, cleared in IDLE) and output timeout_total (16 bits, saturating count of all thresh-in-WAIT events since reset, reset 0).
REQ-029 SHALL, when TIMEOUT_RETRY_STATUS_EN is undefined, omit both ports and their registers; all other behaviour identical.

Verification
REQ-030 SHALL verify clean success: start at cycle 0, ack at cycle 5 -> req pulse cycle 1, done pulse cycle 6 (one cycle), busy cycles 1-6, error never.
REQ-031 SHALL verify single retry: MAX_RETRY=3, BACKOFF=16, thresh in first WAIT -> ctr_clr high 16 BACKOFF cycles, second req pulse, ack -> done; retry_cnt=1 (macro on).
REQ-032 SHALL verify exhaustion: MAX_RETRY=2, thresh every WAIT -> exactly 3 req pulses, then one error pulse, return to IDLE, done never.
REQ-033 SHALL verify ack and thresh high in same WAIT cycle -> done, no retry, retry count unchanged.
REQ-034 SHALL verify abort in BACKOFF and abort coincident with ack in WAIT -> IDLE next cycle, no done/error, start ignored while busy.
REQ-035 SHALL verify rst asserted in WAIT -> all outputs at reset values before next clock edge; timeout_total=0 (macro on).
